// File: rtl/cb_shift_sequencer.sv
// Purpose : sequences one Z80 CB rotate/shift (CB 00-3F): fetch operand, run the external rotate/shift unit, write back.
// Latency : start edge to done = 3 cycles (register operand), 3 + read waits + write waits (memory operand).
// Backpressure: memory read/write requests are held until mem_ack; start is ignored while busy.
//
// Optional feature macro: CB_INDEXED_EN enables DD/FD CB indexed addressing (idx_base + signed disp).
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   start, opcode, hl         - request, CB opcode byte, HL value
//   idx_valid, idx_base, disp - indexed form controls (only used with CB_INDEXED_EN)
//   flags_in / rs_flags_in    - current F; forwarded to the rotate/shift unit for RL/RR carry-in
//   reg_sel/reg_rdata/reg_we  - register file select, read data, write strobe (write data = result)
//   mem_*                     - bus request/response (rd and wr held until ack)
//   rs_data/rs_op/rs_result/rs_flags - rotate/shift unit operand, op select and results
//   result, flags_out, flags_we - registered result and new F with its write strobe
//   busy, done, illegal       - status: busy window, completion pulse, non-rotate-group pulse
module cb_shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] hl,
  input  logic        idx_valid,
  input  logic [15:0] idx_base,
  input  logic [7:0]  disp,
  input  logic [7:0]  flags_in,
  output logic [2:0]  reg_sel,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  rs_data,
  output logic [7:0]  rs_op,
  output logic [7:0]  rs_flags_in,
  input  logic [7:0]  rs_result,
  input  logic [7:0]  rs_flags,
  output logic [7:0]  result,
  output logic [7:0]  flags_out,
  output logic        flags_we,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_op;        // opcode[5:0]: operation and operand select
  logic        r_mem;       // operand lives in memory
  logic [15:0] r_addr;
  logic [7:0]  r_operand;
  logic [7:0]  r_result;
  logic [7:0]  r_flags;
  logic        r_illegal;   // done+illegal pulse for a rejected group

  logic        w_legal;
  logic        w_accept;
  logic        w_start_mem;
  logic [15:0] w_start_addr;
  logic        w_reg_too;   // indexed form with r != (HL): result also goes to register r
  logic [3:0]  w_rs_sel;

  assign w_legal  = (opcode[7:6] == 2'b00);
  // The illegal pulse cycle counts as busy, so a start there is dropped.
  assign w_accept = start && (r_state == S_IDLE) && !r_illegal;

`ifdef CB_INDEXED_EN
  assign w_start_mem  = (opcode[2:0] == 3'b110) || idx_valid;
  assign w_start_addr = idx_valid ? (idx_base + {{8{disp[7]}}, disp}) : hl;
  assign w_reg_too    = r_mem && (r_op[2:0] != 3'b110);
`else
  logic w_unused_idx;
  assign w_unused_idx = ^{idx_valid, idx_base, disp};
  assign w_start_mem  = (opcode[2:0] == 3'b110);
  assign w_start_addr = hl;
  assign w_reg_too    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_legal) w_next = S_RD;
      S_RD:    if (!r_mem || mem_ack) w_next = S_EX;
      S_EX:    w_next = S_WB;
      S_WB:    if (!r_mem || mem_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_we   = 1'b0;
    flags_we = 1'b0;
    case (r_state)
      S_RD: mem_rd = r_mem;
      S_WB: begin
        mem_wr   = r_mem;
        reg_we   = !r_mem || (w_reg_too && mem_ack);
        flags_we = !r_mem || mem_ack;
      end
      default: ;
    endcase
    done = ((r_state == S_WB) && (!r_mem || mem_ack)) || r_illegal;
  end

  assign busy    = (r_state != S_IDLE) || r_illegal;
  assign illegal = r_illegal;

  // Operation select for the rotate/shift unit (note SLL/SRL codes are swapped vs. opcode order)
  always_comb begin
    w_rs_sel = 4'h0;
    case (r_op[5:3])
      3'd0: w_rs_sel = 4'h0;
      3'd1: w_rs_sel = 4'h2;
      3'd2: w_rs_sel = 4'h4;
      3'd3: w_rs_sel = 4'h6;
      3'd4: w_rs_sel = 4'h8;
      3'd5: w_rs_sel = 4'h9;
      3'd6: w_rs_sel = 4'hB;
      3'd7: w_rs_sel = 4'hA;
      default: w_rs_sel = 4'h0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 6'd0;
      r_mem     <= 1'b0;
      r_addr    <= 16'h0000;
      r_operand <= 8'h00;
      r_result  <= 8'h00;
      r_flags   <= 8'h00;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_op   <= opcode[5:0];
        r_mem  <= w_start_mem;
        r_addr <= w_start_addr;
      end
      if (r_state == S_RD) begin
        if (!r_mem) begin
          r_operand <= reg_rdata;
        end else if (mem_ack) begin
          r_operand <= mem_rdata;
        end
      end
      if (r_state == S_EX) begin
        r_result <= rs_result;
        r_flags  <= rs_flags;
      end
    end
  end

  assign reg_sel     = r_op[2:0];
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_result;
  assign result      = r_result;
  assign flags_out   = r_flags;
  assign rs_data     = r_operand;
  assign rs_op       = {4'h0, w_rs_sel};
  assign rs_flags_in = flags_in;

endmodule

// File: tb/tb_cb_shift_sequencer.sv
// Purpose : exercises cb_shift_sequencer with directed and random CB ops against an arithmetic reference model.
// Latency : one operation in flight; expectations queued at issue, compared when done is seen.
// Backpressure: memory responder inserts random (or forced/held) ack wait states.
module tb_cb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  opcode;
  logic [15:0] hl;
  logic        idx_valid;
  logic [15:0] idx_base;
  logic [7:0]  disp;
  logic [7:0]  flags_in;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic [7:0]  rs_data;
  logic [7:0]  rs_op;
  logic [7:0]  rs_flags_in;
  logic [7:0]  rs_result;
  logic [7:0]  rs_flags;
  logic [7:0]  result;
  logic [7:0]  flags_out;
  logic        flags_we;
  logic        busy;
  logic        done;
  logic        illegal;

  cb_shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .hl(hl),
    .idx_valid(idx_valid), .idx_base(idx_base), .disp(disp), .flags_in(flags_in),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rs_data(rs_data), .rs_op(rs_op), .rs_flags_in(rs_flags_in),
    .rs_result(rs_result), .rs_flags(rs_flags),
    .result(result), .flags_out(flags_out), .flags_we(flags_we),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural state seen by the DUT (written only by the stimulus process)
  logic [7:0] regs [8];
  logic [7:0] mem [int];

  function automatic logic [7:0] mem_get(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 37 + 11) & 255);
  endfunction

  assign reg_rdata = regs[reg_sel];

  // Stand-in for the external rotate/shift unit
  function automatic logic [7:0] flag_byte(input logic [7:0] r, input logic c);
    return {r[7], (r == 8'h00), 3'b000, ~^r, 1'b0, c};
  endfunction

  function automatic logic [15:0] rs_unit(input logic [7:0] op, input logic [7:0] d, input logic [7:0] f);
    logic [7:0] r;
    logic       c;
    r = 8'h00;
    c = 1'b0;
    case (op[3:0])
      4'h0: begin r = {d[6:0], d[7]}; c = d[7]; end
      4'h2: begin r = {d[0], d[7:1]}; c = d[0]; end
      4'h4: begin r = {d[6:0], f[0]}; c = d[7]; end
      4'h6: begin r = {f[0], d[7:1]}; c = d[0]; end
      4'h8: begin r = {d[6:0], 1'b0}; c = d[7]; end
      4'h9: begin r = {d[7], d[7:1]}; c = d[0]; end
      4'hB: begin r = {d[6:0], 1'b1}; c = d[7]; end
      4'hA: begin r = {1'b0, d[7:1]}; c = d[0]; end
      default: begin r = 8'h00; c = 1'b0; end
    endcase
    return {flag_byte(r, c), r};
  endfunction

  assign {rs_flags, rs_result} = rs_unit(rs_op, rs_data, rs_flags_in);

  // Reference: CB operation by opcode[5:3] in integer arithmetic
  function automatic void ref_op(input int op, input int v, input int cin, output int res, output int fl);
    int cy;
    case (op)
      0: begin cy = v / 128; res = (v * 2) % 256 + cy; end         // RLC
      1: begin cy = v % 2;   res = v / 2 + cy * 128; end           // RRC
      2: begin cy = v / 128; res = (v * 2) % 256 + cin; end        // RL
      3: begin cy = v % 2;   res = v / 2 + cin * 128; end          // RR
      4: begin cy = v / 128; res = (v * 2) % 256; end              // SLA
      5: begin cy = v % 2;   res = v / 2 + (v / 128) * 128; end    // SRA
      6: begin cy = v / 128; res = (v * 2) % 256 + 1; end          // SLL
      default: begin cy = v % 2; res = v / 2; end                  // SRL
    endcase
    fl = cy;
    if (res >= 128) fl += 128;
    if (res == 0) fl += 64;
    if ($countones(res) % 2 == 0) fl += 4;
  endfunction

  typedef struct {
    int t0;
    bit ill;
    bit is_mem;
    bit reg_too;
    int r;
    int addr;
    int res;
    int fl;
  } exp_t;

  exp_t sb[$];

  // Memory responder
  bit hold_ack   = 1'b0;
  int force_wait = -1;
  int wcnt       = -1;
  int rd_addr    = 0;

  always @(posedge clk) begin
    #1;
    if (reset || mem_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (reset) wcnt = -1;
    end else if ((mem_rd || mem_wr) && !hold_ack) begin
      if (wcnt < 0) wcnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      if (wcnt == 0) begin
        mem_ack = 1'b1;
        wcnt    = -1;
        if (mem_rd) begin
          mem_rdata = mem_get(int'(mem_addr));
          rd_addr   = int'(mem_addr);
        end
      end else begin
        wcnt--;
      end
    end
  end

  // Monitor / scoreboard
  exp_t mon_e;
  int   req_cnt = 0;
  int   n_memwr = 0;
  int   lat;

  always @(negedge clk) begin
    if (reset) begin
      req_cnt = 0;
      sb.delete();
    end else begin
      if (mem_rd || mem_wr) begin
        req_cnt++;
        check("rd_wr_overlap", 32'(mem_rd & mem_wr), 32'(0));
      end
      if (mem_wr && mem_ack) n_memwr++;
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'(done), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          lat   = cyc - mon_e.t0;
          check("illegal", 32'(illegal), 32'(mon_e.ill));
          if (mon_e.ill) begin
            check("ill_latency", lat, 1);
            check("ill_reg_we", 32'(reg_we), 32'(0));
            check("ill_flags_we", 32'(flags_we), 32'(0));
            check("ill_mem_wr", 32'(mem_wr), 32'(0));
            check("ill_mem_rd", 32'(mem_rd), 32'(0));
          end else begin
            check("result", 32'(result), mon_e.res);
            check("flags_out", 32'(flags_out), mon_e.fl);
            check("flags_we", 32'(flags_we), 32'(1));
            if (mon_e.is_mem) begin
              check("mem_latency", lat, req_cnt + 1);
              check("mem_wr", 32'(mem_wr), 32'(1));
              check("mem_wr_addr", 32'(mem_addr), mon_e.addr);
              check("mem_rd_addr", rd_addr, mon_e.addr);
              check("mem_wdata", 32'(mem_wdata), mon_e.res);
              check("mem_reg_we", 32'(reg_we), 32'(mon_e.reg_too));
            end else begin
              check("reg_latency", lat, 3);
              check("reg_we", 32'(reg_we), 32'(1));
              check("reg_sel", 32'(reg_sel), mon_e.r);
              check("reg_mem_wr", 32'(mem_wr), 32'(0));
            end
          end
        end
        req_cnt = 0;
      end
    end
  end

  // Stimulus
  bit pend_reg = 1'b0;
  bit pend_mem = 1'b0;
  int pend_r, pend_addr, pend_val;

  task automatic apply_pending();
    if (pend_reg) regs[pend_r] = 8'(pend_val);
    if (pend_mem) mem[pend_addr] = 8'(pend_val);
    pend_reg = 1'b0;
    pend_mem = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'(0));
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] h, input logic iv,
                       input logic [15:0] ib, input logic [7:0] d, input logic [7:0] f);
    exp_t e;
    int   v;
    int   a;
    wait_idle();
    apply_pending();
    e.t0     = cyc;
    e.ill    = (op[7:6] != 2'b00);
    e.r      = int'(op[2:0]);
    e.is_mem = (op[2:0] == 3'b110);
    a        = int'(h);
`ifdef CB_INDEXED_EN
    if (iv) begin
      int sd;
      sd = (int'(d) >= 128) ? int'(d) - 256 : int'(d);
      a = (int'(ib) + sd + 65536) % 65536;
      e.is_mem = 1'b1;
    end
`endif
    e.addr    = a;
    e.reg_too = e.is_mem && (e.r != 6);
    v = e.is_mem ? int'(mem_get(a)) : int'(regs[e.r]);
    ref_op(int'(op[5:3]), v, int'(f[0]), e.res, e.fl);
    if (!e.ill) begin
      pend_mem  = e.is_mem;
      pend_reg  = !e.is_mem || e.reg_too;
      pend_r    = e.r;
      pend_addr = a;
      pend_val  = e.res;
    end
    opcode    = op;
    hl        = h;
    idx_valid = iv;
    idx_base  = ib;
    disp      = d;
    flags_in  = f;
    start     = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Extra start while busy: must be ignored
  task automatic spurious();
    if (busy) begin
      opcode = 8'($urandom);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int wr0;
    reset     = 1'b1;
    start     = 1'b0;
    opcode    = 8'h00;
    hl        = 16'h0000;
    idx_valid = 1'b0;
    idx_base  = 16'h0000;
    disp      = 8'h00;
    flags_in  = 8'h00;
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_illegal", 32'(illegal), 32'(0));
    check("rst_strobes", 32'({reg_we, mem_rd, mem_wr, flags_we}), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_flags_out", 32'(flags_out), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    reset = 1'b0;

    // RLC B with B=0x85
    regs[0] = 8'h85;
    issue(8'h00, 16'h1234, 1'b0, 16'h0000, 8'h00, 8'h00);

    // SRL (HL), HL=0x4000, mem=0x01, ack two cycles late
    wait_idle();
    apply_pending();
    mem[32'h4000] = 8'h01;
    force_wait = 2;
    issue(8'h3E, 16'h4000, 1'b0, 16'h0000, 8'h00, 8'h00);
    wait_idle();
    force_wait = -1;

    // BIT group: rejected
    issue(8'h40, 16'h4000, 1'b0, 16'h0000, 8'h00, 8'h00);

    // Start during busy is ignored
    issue(8'h11, 16'h4001, 1'b0, 16'h0000, 8'h00, 8'h01);
    spurious();

`ifdef CB_INDEXED_EN
    issue(8'h06, 16'h4000, 1'b1, 16'h1000, 8'hFE, 8'h00);
    issue(8'h01, 16'h4000, 1'b1, 16'h1000, 8'h05, 8'h01);
`endif

    // Random mix
    for (int i = 0; i < 200; i++) begin
      logic [7:0]  op;
      logic [15:0] h;
      op = 8'($urandom);
      if ($urandom_range(0, 7) != 0) op[7:6] = 2'b00;
      h = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'h4000 + 16'($urandom_range(0, 3));
      issue(op, h, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) spurious();
    end

    // Reset in the middle of a memory read
    hold_ack = 1'b1;
    issue(8'h06, 16'h4002, 1'b0, 16'h0000, 8'h00, 8'h01);
    n = 0;
    while (!mem_rd && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_rd_active", 32'(mem_rd), 32'(1));
    wr0   = n_memwr;
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_rd", 32'(mem_rd), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    reset    = 1'b0;
    hold_ack = 1'b0;
    pend_reg = 1'b0;
    pend_mem = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_write", n_memwr - wr0, 32'(0));

    // Sequencer still usable after the abort
    issue(8'h2F, 16'h4003, 1'b0, 16'h0000, 8'h00, 8'h00);
    wait_idle();
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
